// File: rtl/inst_encode_loader_if.sv
// Request/write bus of inst_encode_loader.
// The master side drives instruction fields over a valid/ready handshake.
// The slave side returns ready and drives the instruction-memory write port.
interface inst_encode_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    logic [25:0]       target26;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm16, target26,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm16, target26,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/inst_encode_loader.sv
// inst_encode_loader: encodes MIPS R/I/J/NOP requests into 32-bit words and
// writes them to instruction memory at consecutive word addresses, one write
// per accepted request, one cycle after acceptance.
// Optional feature macro: INST_LEGAL_CHECK_EN -- when defined, requests outside
// the decoder-supported set are consumed without a write and err_illegal pulses.
module inst_encode_loader #(
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         finish,
    inst_encode_loader_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         done,
    output logic                         err_illegal
);
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;   // address of the next word to write
    logic [ADDR_W-1:0] addr_q, addr_d;     // address presented with the strobe
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              in_ready;
    logic              accept;
    logic              legal;

    function automatic logic [31:0] encode(
        input logic [1:0]  fmt,
        input logic [5:0]  opcode,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm16,
        input logic [25:0] target26
    );
        logic [31:0] word;
        unique case (fmt)
            2'b00:   word = {6'b000000, rs, rt, rd, shamt, funct};
            2'b01:   word = {opcode, rs, rt, imm16};
            2'b10:   word = {opcode, target26};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

`ifdef INST_LEGAL_CHECK_EN
    // Mirrors the opcode set that main_decoder understands.
    function automatic logic is_legal(
        input logic [1:0] fmt,
        input logic [5:0] opcode,
        input logic [4:0] rs,
        input logic [4:0] rt
    );
        logic ok;
        ok = 1'b1;
        unique case (fmt)
            2'b01: begin
                case (opcode)
                    6'b001100, 6'b001101, 6'b001110, 6'b001111,      // ANDI ORI XORI LUI
                    6'b001000, 6'b001001, 6'b001010, 6'b001011,      // ADDI ADDIU SLTI SLTIU
                    6'b100000, 6'b100100, 6'b100001, 6'b100101,      // LB LBU LH LHU
                    6'b100011, 6'b101000, 6'b101001, 6'b101011,      // LW SB SH SW
                    6'b000100, 6'b000101, 6'b000111, 6'b000110:      // BEQ BNE BGTZ BLEZ
                        ok = 1'b1;
                    6'b000001: ok = (rt == 5'b00000) || (rt == 5'b00001) ||
                                    (rt == 5'b10000) || (rt == 5'b10001);   // REGIMM
                    6'b010000: ok = (rs == 5'b00000) || (rs == 5'b00100);   // COP0
                    default:   ok = 1'b0;
                endcase
            end
            2'b10:   ok = (opcode == 6'b000010) || (opcode == 6'b000011);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

    // Next-state and next-output computation for the load session.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        count_d = count_q;
        waddr_d = waddr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        in_ready = (state_q == ST_LOAD) && !full_q && !start && !finish;
        accept   = bus.in_valid && in_ready;
`ifdef INST_LEGAL_CHECK_EN
        legal    = is_legal(bus.fmt, bus.opcode, bus.rs, bus.rt);
`else
        legal    = 1'b1;
`endif

        if (start) begin
            state_d = ST_LOAD;
            count_d = '0;
            waddr_d = BASE_ADDR;
            addr_d  = BASE_ADDR;
        end else if (finish) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end else if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                addr_d  = waddr_q;
                wdata_d = encode(bus.fmt, bus.opcode, bus.rs, bus.rt, bus.rd,
                                 bus.shamt, bus.funct, bus.imm16, bus.target26);
                waddr_d = waddr_q + ADDR_W'(4);
                count_d = count_q + CNT_W'(1);
                if (count_d == DEPTH_C) begin
                    state_d = ST_FULL;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        full_d = (count_d == DEPTH_C);
    end

    // Session state and registered outputs; reset drops any pending write.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block's body only.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            waddr_q <= BASE_ADDR;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            we_q    <= 1'b0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            count_q <= count_d;
            waddr_q <= waddr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            full_q  <= full_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign count          = count_q;
    assign full           = full_q;
    assign done           = done_q;
    assign err_illegal    = err_q;
endmodule
